div_result_reconstructor: RTL and testbench

- Inverse checker for the 16/8 array dividers.
- Takes a dividend n, divisor d and a divider's quotient q and remainder r, and rebuilds n_rec = q*d + r with an 8-cycle sequential shift-add multiplier.
- Reports the signed error n_rec - n plus validity flags, so exact and approximate divider variants can be scored for error/MSE in the characterisation harness.
- Sits downstream of a divider instance in the test/evaluation wrapper, with valid/ready on both sides.

---
 rtl/divrc_pkg.sv | 48 ++++
 rtl/divrc_shift_add_mul.sv | 86 ++++++++
 rtl/div_result_reconstructor.sv | 171 +++++++++++++++++
 tb/tb_div_result_reconstructor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/divrc_pkg.sv
// ---------------------------------------------------------------------------
// divrc_pkg
// Shared types and constants for the division-result reconstructor.
//   - NW   : dividend / reconstruction width (always 2*DW)
//   - DW   : divisor / quotient / remainder width
//   - ERRW : signed error width (NW + 1)
//   - SQW  : squared-error accumulator width
//   - CNTW : sample counter width
//   - state_e  : control FSM states
//   - flags_t  : result flag bundle
//   - capture_flags() : operand-derived flags, computed at accept time
// ---------------------------------------------------------------------------
package divrc_pkg;

    localparam int NW   = 16;
    localparam int DW   = 8;
    localparam int ERRW = 17;
    localparam int SQW  = 40;
    localparam int CNTW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic mismatch;
        logic div_by_zero;
        logic rem_invalid;
        logic q_ovf;
    } flags_t;

    // Flags that depend only on the operands. mismatch is produced later,
    // once the reconstruction is known, so it is left at 0 here.
    function automatic flags_t capture_flags(input logic [NW-1:0] n,
                                             input logic [DW-1:0] d,
                                             input logic [DW-1:0] r);
        flags_t f;
        f             = '0;
        f.div_by_zero = (d == '0);
        f.rem_invalid = (d != '0) && (r >= d);
        // Compare in NW+1 bits so d<<DW cannot wrap.
        f.q_ovf       = ({1'b0, n} >= ({{(NW+1-DW){1'b0}}, d} << DW));
        return f;
    endfunction

endpackage

// File: rtl/divrc_shift_add_mul.sv
// ---------------------------------------------------------------------------
// divrc_shift_add_mul
// Sequential shift-add multiplier computing q*d + r over exactly DW cycles.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : load operands (acc = r, qsh = q, cnt = 0) and begin
//   d, q, r      : operands sampled on start
//   busy         : a multiplication is in progress
//   done         : high during the last step cycle (cnt == DW-1)
//   acc_next     : accumulator value being written this cycle; equals the
//                  final q*d + r while done is high
// ---------------------------------------------------------------------------
module divrc_shift_add_mul
    import divrc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] d,
    input  logic [DW-1:0] q,
    input  logic [DW-1:0] r,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] acc_next
);

    localparam int CW = $clog2(DW);

    logic [NW-1:0] acc_q, acc_d;
    logic [DW-1:0] qsh_q, qsh_d;
    logic [DW-1:0] dsh_q, dsh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [NW-1:0] addend;
    logic          last_step;

    assign addend    = {{(NW-DW){1'b0}}, dsh_q} << cnt_q;
    assign last_step = busy_q && (cnt_q == CW'(DW-1));

    always_comb begin
        acc_d  = acc_q;
        qsh_d  = qsh_q;
        dsh_d  = dsh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            acc_d  = {{(NW-DW){1'b0}}, r};
            qsh_d  = q;
            dsh_d  = d;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Max q*d + r = 65280, so the NW-bit sum never wraps.
            if (qsh_q[0]) begin
                acc_d = acc_q + addend;
            end
            qsh_d = qsh_q >> 1;
            cnt_d = cnt_q + CW'(1);
            // No early exit on q == 0: always DW steps.
            if (last_step) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            qsh_q  <= '0;
            dsh_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            qsh_q  <= qsh_d;
            dsh_q  <= dsh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = last_step;
    assign acc_next = acc_d;

endmodule

// File: rtl/div_result_reconstructor.sv
// ---------------------------------------------------------------------------
// div_result_reconstructor
// Rebuilds n_rec = q*d + r from a divider's outputs and reports the signed
// error n_rec - n with validity flags, for scoring exact and approximate
// 16/8 dividers.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid / in_ready      : operand handshake (n, d, q, r)
//   out_valid / out_ready    : result handshake
//   n_rec, err, mismatch     : reconstruction, n_rec - n (17b two's compl.),
//                              err != 0
//   div_by_zero, rem_invalid, q_ovf : operand-derived flags
// Optional build macro DIVRC_SQERR_ACC_EN adds:
//   acc_clr    : clear the accumulators (wins over a coincident handshake)
//   sq_err_sum : saturating sum of err^2 over accepted results
//   sample_cnt : saturating count of accepted results
// Results stay on n_rec/err/flags after returning to IDLE; out_valid is the
// only qualifier.
// ---------------------------------------------------------------------------
module div_result_reconstructor
    import divrc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NW-1:0]   n,
    input  logic [DW-1:0]   d,
    input  logic [DW-1:0]   q,
    input  logic [DW-1:0]   r,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NW-1:0]   n_rec,
    output logic [ERRW-1:0] err,
`ifdef DIVRC_SQERR_ACC_EN
    input  logic            acc_clr,
    output logic [SQW-1:0]  sq_err_sum,
    output logic [CNTW-1:0] sample_cnt,
`endif
    output logic            mismatch,
    output logic            div_by_zero,
    output logic            rem_invalid,
    output logic            q_ovf
);

    state_e          state_q, state_d;
    logic [NW-1:0]   n_q, n_d;
    flags_t          flags_q, flags_d;
    logic [NW-1:0]   n_rec_q, n_rec_d;
    logic [ERRW-1:0] err_q, err_d;
    logic [ERRW-1:0] err_next;
    logic            start;
    logic            mul_busy;
    logic            mul_done;
    logic [NW-1:0]   acc_next;

    divrc_shift_add_mul u_mul (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .d        (d),
        .q        (q),
        .r        (r),
        .busy     (mul_busy),
        .done     (mul_done),
        .acc_next (acc_next)
    );

    // Both operands zero-extended into ERRW bits, so the difference is a
    // correct two's complement value.
    assign err_next = ERRW'(acc_next) - ERRW'(n_q);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        flags_d = flags_q;
        n_rec_d = n_rec_q;
        err_d   = err_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    start            = 1'b1;
                    n_d              = n;
                    flags_d          = capture_flags(n, d, r);
                    flags_d.mismatch = flags_q.mismatch;
                    state_d          = MUL;
                end
            end
            MUL: begin
                if (mul_done) begin
                    n_rec_d          = acc_next;
                    err_d            = err_next;
                    flags_d.mismatch = (err_next != '0);
                    state_d          = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            flags_q <= '0;
            n_rec_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            flags_q <= flags_d;
            n_rec_q <= n_rec_d;
            err_q   <= err_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign n_rec       = n_rec_q;
    assign err         = err_q;
    assign mismatch    = flags_q.mismatch;
    assign div_by_zero = flags_q.div_by_zero;
    assign rem_invalid = flags_q.rem_invalid;
    assign q_ovf       = flags_q.q_ovf;

`ifdef DIVRC_SQERR_ACC_EN
    logic [SQW-1:0]    sq_sum_q, sq_sum_d;
    logic [CNTW-1:0]   smp_cnt_q, smp_cnt_d;
    logic [ERRW-1:0]   err_abs;
    logic [2*ERRW-1:0] sq_term;
    logic [SQW:0]      sq_sum_ext;
    logic              hs;

    assign hs         = out_valid && out_ready;
    assign err_abs    = err_q[ERRW-1] ? (~err_q + ERRW'(1)) : err_q;
    assign sq_term    = {{ERRW{1'b0}}, err_abs} * {{ERRW{1'b0}}, err_abs};
    assign sq_sum_ext = {1'b0, sq_sum_q} + {{(SQW+1-2*ERRW){1'b0}}, sq_term};

    always_comb begin
        sq_sum_d  = sq_sum_q;
        smp_cnt_d = smp_cnt_q;
        if (acc_clr) begin
            sq_sum_d  = '0;
            smp_cnt_d = '0;
        end else if (hs) begin
            sq_sum_d  = sq_sum_ext[SQW] ? '1 : sq_sum_ext[SQW-1:0];
            smp_cnt_d = (smp_cnt_q == '1) ? smp_cnt_q : smp_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_sum_q  <= '0;
            smp_cnt_q <= '0;
        end else begin
            sq_sum_q  <= sq_sum_d;
            smp_cnt_q <= smp_cnt_d;
        end
    end

    assign sq_err_sum = sq_sum_q;
    assign sample_cnt = smp_cnt_q;
`endif

endmodule

// File: tb/tb_div_result_reconstructor.sv
module tb_div_result_reconstructor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] n_s;
    logic [7:0]  d_s;
    logic [7:0]  q_s;
    logic [7:0]  r_s;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] n_rec;
    logic [16:0] err;
    logic        mismatch;
    logic        div_by_zero;
    logic        rem_invalid;
    logic        q_ovf;
`ifdef DIVRC_SQERR_ACC_EN
    logic        acc_clr;
    logic [39:0] sq_err_sum;
    logic [31:0] sample_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference accumulator state (only meaningful with the option built in)
    longint m_sq  = 0;
    longint m_cnt = 0;

    always #5 clk = ~clk;

    div_result_reconstructor dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .n           (n_s),
        .d           (d_s),
        .q           (q_s),
        .r           (r_s),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .n_rec       (n_rec),
        .err         (err),
`ifdef DIVRC_SQERR_ACC_EN
        .acc_clr     (acc_clr),
        .sq_err_sum  (sq_err_sum),
        .sample_cnt  (sample_cnt),
`endif
        .mismatch    (mismatch),
        .div_by_zero (div_by_zero),
        .rem_invalid (rem_invalid),
        .q_ovf       (q_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; waits (bounded) for in_ready.
    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            if (in_ready === 1'b1) break;
            @(negedge clk);
        end
        chk("in_ready_timeout", in_ready, 1);
    endtask

    task automatic check_acc();
`ifdef DIVRC_SQERR_ACC_EN
        chk("sq_err_sum", sq_err_sum, m_sq);
        chk("sample_cnt", sample_cnt, m_cnt);
`endif
    endtask

    // One full transaction. hold = cycles of out_ready=0 in DONE with junk
    // in_valid traffic; clr = assert acc_clr on the handshake cycle.
    task automatic run_op(input int nn, input int dd, input int qq, input int rr,
                          input int hold, input bit clr);
        int          e_nrec;
        int          e_err;
        logic [16:0] e_err17;
        bit          e_dz, e_ri, e_qo;
        e_nrec  = qq * dd + rr;
        e_err   = e_nrec - nn;
        e_err17 = 17'(e_err);
        e_dz    = (dd == 0);
        e_ri    = (dd != 0) && (rr >= dd);
        e_qo    = (nn >= dd * 256);

        wait_ready();
        n_s = 16'(nn); d_s = 8'(dd); q_s = 8'(qq); r_s = 8'(rr);
        in_valid = 1'b1;
        @(posedge clk);                 // accept edge
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_in_ready", in_ready, 0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("early_out_valid", out_valid, 0);
        @(posedge clk);                 // 9th edge counting the accept edge
        @(negedge clk);
        chk("latency_out_valid", out_valid, 1);
        chk("n_rec", n_rec, 64'(e_nrec));
        chk("err", err, e_err17);
        chk("mismatch", mismatch, (e_err != 0));
        chk("div_by_zero", div_by_zero, e_dz);
        chk("rem_invalid", rem_invalid, e_ri);
        chk("q_ovf", q_ovf, e_qo);
        chk("done_in_ready", in_ready, 0);

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            n_s = 16'($urandom); d_s = 8'($urandom); q_s = 8'($urandom); r_s = 8'($urandom);
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_n_rec", n_rec, 64'(e_nrec));
            chk("hold_err", err, e_err17);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;

        out_ready = 1'b1;
`ifdef DIVRC_SQERR_ACC_EN
        acc_clr = clr;
`endif
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
`ifdef DIVRC_SQERR_ACC_EN
        acc_clr = 1'b0;
`endif
        if (clr) begin
            m_sq  = 0;
            m_cnt = 0;
        end else begin
            m_sq = m_sq + longint'(e_err) * longint'(e_err);
            if (m_sq > 64'hFF_FFFF_FFFF) m_sq = 64'hFF_FFFF_FFFF;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_n_rec_held", n_rec, 64'(e_nrec));
        chk("post_hs_err_held", err, e_err17);
        check_acc();
        $display("op n=%0d d=%0d q=%0d r=%0d -> n_rec=%0d err=%0d", nn, dd, qq, rr, e_nrec, e_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        n_s = '0; d_s = '0; q_s = '0; r_s = '0;
`ifdef DIVRC_SQERR_ACC_EN
        acc_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_n_rec", n_rec, 0);
        chk("rst_err", err, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_div_by_zero", div_by_zero, 0);
        chk("rst_rem_invalid", rem_invalid, 0);
        chk("rst_q_ovf", q_ovf, 0);
        check_acc();

        // Exact, high-side and low-side approximate results
        run_op(1000, 7, 142, 6, 0, 1'b0);
        run_op(1000, 7, 143, 6, 0, 1'b0);
        run_op(1000, 7, 141, 0, 0, 1'b0);
        // Explicit values for the accumulated squared error (49 + 169)
`ifdef DIVRC_SQERR_ACC_EN
        chk("sq_sum_218", sq_err_sum, 218);
        chk("sample_cnt_3", sample_cnt, 3);
`endif

        // Flag cases
        run_op(300, 0, 255, 44, 0, 1'b0);
        run_op(65535, 1, 255, 255, 0, 1'b0);

        // Backpressure: 5 cycles of out_ready=0 with ignored in_valid
        run_op(40000, 200, 200, 0, 5, 1'b0);

        // acc_clr on the handshake cycle drops the sample
        run_op(1000, 7, 143, 6, 0, 1'b1);
`ifdef DIVRC_SQERR_ACC_EN
        chk("clr_sq_zero", sq_err_sum, 0);
        chk("clr_cnt_zero", sample_cnt, 0);
`endif

        // Reset during MUL cycle 4: operand discarded
        wait_ready();
        n_s = 16'd5000; d_s = 8'd50; q_s = 8'd100; r_s = 8'd0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_sq = 0; m_cnt = 0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_n_rec", n_rec, 0);
        chk("midrst_err", err, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", out_valid, 0);
        end
        check_acc();
        $display("op midrst n=5000 d=50 q=100 r=0 -> discarded");

        // Randomized traffic against the arithmetic model
        for (int k = 0; k < 24; k++) begin
            int rn, rd, rq, rr;
            rn = int'($urandom_range(0, 65535));
            rd = int'($urandom_range(0, 255));
            if (($urandom_range(0, 1) == 1) && rd != 0 && (rn / rd) < 256) begin
                rq = rn / rd;
                rr = rn % rd;
                if ($urandom_range(0, 1) == 1) rq = (rq + int'($urandom_range(0, 2))) % 256;
            end else begin
                rq = int'($urandom_range(0, 255));
                rr = int'($urandom_range(0, 255));
            end
            run_op(rn, rd, rq, rr, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
